// File: rtl/gs_dac_mixer.sv
// General Sound DAC mixer: time-multiplexed shift-add volume scaling of four channels,
// stereo accumulation, and first-order sigma-delta bitstreams for the RC output filters.
module gs_dac_mixer (
   input  logic        clk32,
   input  logic        rst_n,
   input  logic [7:0]  dac0,
   input  logic [7:0]  dac1,
   input  logic [7:0]  dac2,
   input  logic [7:0]  dac3,
   input  logic [5:0]  vol0,
   input  logic [5:0]  vol1,
   input  logic [5:0]  vol2,
   input  logic [5:0]  vol3,
   input  logic        mute,
   output logic [14:0] mix_l,
   output logic [14:0] mix_r,
   output logic        mix_stb,
   output logic        sd_l,
   output logic        sd_r
);

   logic [4:0]  fcnt_q;
   logic [13:0] samp_q, samp_d;
   logic [6:0]  vol_q, vol_d;
   logic [13:0] prod_q, prod_d;
   logic [14:0] acc_l_q, acc_l_d, acc_r_q, acc_r_d;
   logic [14:0] mix_l_q, mix_l_d, mix_r_q, mix_r_d;
   logic        mix_stb_q;
   logic [15:0] sd_acc_l_q, sd_acc_l_d, sd_acc_r_q, sd_acc_r_d;
   logic        sd_l_q, sd_r_q;

   logic [7:0]  dac_sel, dac_x;
   logic [5:0]  vol_sel;
   logic [13:0] prod_next;
   logic [14:0] prod_ext;
   logic        slot_load, slot_end, frame_end;
   logic [14:0] u_l, u_r;

   assign slot_load = (fcnt_q[2:0] == 3'd0);
   assign slot_end  = (fcnt_q[2:0] == 3'd7);
   assign frame_end = (fcnt_q == 5'd31);

   always_comb begin
      dac_sel = dac0;
      vol_sel = vol0;
      unique case (fcnt_q[4:3])
         2'd0: begin dac_sel = dac0; vol_sel = vol0; end
         2'd1: begin dac_sel = dac1; vol_sel = vol1; end
         2'd2: begin dac_sel = dac2; vol_sel = vol2; end
         2'd3: begin dac_sel = dac3; vol_sel = vol3; end
         default: ;
      endcase
   end

   assign dac_x     = dac_sel ^ 8'h80;
   assign prod_next = prod_q + (vol_q[0] ? samp_q : 14'd0);
   assign prod_ext  = {prod_next[13], prod_next};

   always_comb begin
      samp_d  = samp_q;
      vol_d   = vol_q;
      prod_d  = prod_q;
      acc_l_d = acc_l_q;
      acc_r_d = acc_r_q;
      mix_l_d = mix_l_q;
      mix_r_d = mix_r_q;
      if (slot_load) begin
         samp_d = {{6{dac_x[7]}}, dac_x};
         vol_d  = (vol_sel == 6'd63) ? 7'd64 : {1'b0, vol_sel};
         prod_d = 14'd0;
      end else begin
         // Walk the volume LSB-first while the sample doubles each cycle.
         prod_d = prod_next;
         samp_d = samp_q << 1;
         vol_d  = vol_q >> 1;
      end
      if (slot_end) begin
         if (fcnt_q[4]) acc_r_d = acc_r_q + prod_ext;
         else           acc_l_d = acc_l_q + prod_ext;
      end
      if (frame_end) begin
         // acc_r_d already holds channel 3's product completed this cycle.
         mix_l_d = mute ? 15'd0 : acc_l_d;
         mix_r_d = mute ? 15'd0 : acc_r_d;
         acc_l_d = 15'd0;
         acc_r_d = 15'd0;
      end
   end

   // Offset to unsigned by flipping the sign weight: u = mix + 16384.
   assign u_l = mix_l_q + 15'd16384;
   assign u_r = mix_r_q + 15'd16384;
   assign sd_acc_l_d = {1'b0, sd_acc_l_q[14:0]} + {1'b0, u_l};
   assign sd_acc_r_d = {1'b0, sd_acc_r_q[14:0]} + {1'b0, u_r};

   always_ff @(posedge clk32 or negedge rst_n) begin
      if (!rst_n) begin
         fcnt_q     <= 5'd0;
         samp_q     <= 14'd0;
         vol_q      <= 7'd0;
         prod_q     <= 14'd0;
         acc_l_q    <= 15'd0;
         acc_r_q    <= 15'd0;
         mix_l_q    <= 15'd0;
         mix_r_q    <= 15'd0;
         mix_stb_q  <= 1'b0;
         sd_acc_l_q <= 16'd0;
         sd_acc_r_q <= 16'd0;
         sd_l_q     <= 1'b0;
         sd_r_q     <= 1'b0;
      end else begin
         fcnt_q     <= fcnt_q + 5'd1;
         samp_q     <= samp_d;
         vol_q      <= vol_d;
         prod_q     <= prod_d;
         acc_l_q    <= acc_l_d;
         acc_r_q    <= acc_r_d;
         mix_l_q    <= mix_l_d;
         mix_r_q    <= mix_r_d;
         mix_stb_q  <= frame_end;
         sd_acc_l_q <= sd_acc_l_d;
         sd_acc_r_q <= sd_acc_r_d;
         sd_l_q     <= sd_acc_l_q[15];
         sd_r_q     <= sd_acc_r_q[15];
      end
   end

   assign mix_l   = mix_l_q;
   assign mix_r   = mix_r_q;
   assign mix_stb = mix_stb_q;
   assign sd_l    = sd_l_q;
   assign sd_r    = sd_r_q;

endmodule
